mux_rr_4to1: RTL and testbench
==============================

# mux_rr_4to1

Four-lane round-robin merge stage that sits directly upstream of the serializing output mux. It drains four show-ahead lane FIFOs into a single registered byte stream: it pops at most one FIFO per cycle, serves the non-empty lanes in fair rotation, and stalls when the downstream stage asserts `pause`. It is written as behavioural RTL that synthesizes onto the team's CMOS cell set (NOT/NAND/NOR/DFF/DFFSR).

## Interface
Parameters:
- `BW`, 8, data width of each lane and of the output.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `reset_L`  input  1  asynchronous, active-low reset.
- `data_in0`..`data_in3`  input  BW each  head-of-FIFO word of lanes 0..3 (show-ahead).
- `empty`  input  4  bit k high = lane k FIFO empty.
- `pause`  input  1  downstream back-pressure; high = do not emit.
- `pop`  output  4  combinational one-hot (or zero) pop to the lane FIFOs.
- `data_out`  output  BW  registered merged word.
- `valid_out`  output  1  registered; high = `data_out` is a new word this cycle.
- `lane_out`  output  2  registered index of the lane that produced `data_out`.

## Operation
- State machine `state`: `INIT` and `ACTIVE`. Reset forces `INIT`. `INIT` -> `ACTIVE` on the first rising edge with `reset_L` high. `ACTIVE` holds until the next reset. No pops are issued in `INIT`.
- A 2-bit pointer `ptr` holds the highest-priority lane. Search order is `ptr`, `ptr+1`, `ptr+2`, `ptr+3` (mod 4). The selected lane is the first lane in that order with `empty[k]`=0.
- Grant condition: `state`=`ACTIVE`, `pause`=0, `reset_L`=1, and at least one lane non-empty.
- On a grant of lane k:
  - `pop[k]`=1 in the same cycle; all other `pop` bits are 0.
  - At the next edge: `data_out`<=`data_in`k, `lane_out`<=k, `valid_out`<=1, `ptr`<=k+1 (wraps 3 -> 0).
- With no grant: `pop`=0. At the next edge `valid_out`<=0, while `data_out`, `lane_out` and `ptr` hold.
- `pop` is never asserted for an empty lane. It is never multi-hot.
- Reset values: `data_out`=0, `lane_out`=0, `valid_out`=0, `ptr`=0, `state`=`INIT`. `pop`=0 while `reset_L` is low.

## Timing
- Latency: pop in cycle N -> word on `data_out` with `valid_out`=1 in cycle N+1. Throughput is one word per cycle.
- `pause` is sampled combinationally. Asserting it in cycle N blocks the pop in N, and `valid_out` is 0 in N+1. Deasserting it allows a pop in the same cycle.
- Simultaneous events: all four lanes non-empty with `pause`=0 gives grants to lanes 0,1,2,3,0,… on consecutive cycles. A lane that becomes empty is skipped with no bubble cycle.
- A lane whose `empty` rises in the same cycle it would be selected is not popped. Selection uses the current `empty` only.
- Reset mid-operation: registered outputs clear asynchronously on the falling edge of `reset_L`, and `pop` drops immediately. A word in flight is discarded. After release, one `INIT` cycle occurs before the first pop.

## Configuration
- `MUX_PARITY_EN`:
  - Defined: an extra output `parity_out` (1 bit) is added. It is registered alongside `data_out` and equals the XOR of all bits of the selected `data_in`k (even parity). It resets to 0 and holds when there is no grant.
  - Undefined: the port and its logic are absent, and all other behaviour is identical.

## Test plan
- Reset: hold `reset_L`=0 with all lanes non-empty -> `pop`=0, `data_out`=0x00, `valid_out`=0. After release, the first pop occurs on the 2nd edge (the `INIT` cycle is skipped for popping).
- Full rotation: `empty`=4'b0000, `data_in0..3`=0xA0,0xB1,0xC2,0xD3, `pause`=0 -> `pop`=0001,0010,0100,1000,0001. `data_out`=0xA0,0xB1,0xC2,0xD3,0xA0 one cycle later, with `valid_out` continuously 1 and `lane_out`=0,1,2,3,0.
- Skip empties: `empty`=4'b1010 (lanes 1,3 empty), `ptr`=1 -> lane 2 is popped, then lane 0, then lane 2. Lanes 1 and 3 are never popped.
- Pause: stream running, `pause`=1 for 3 cycles -> `pop`=0 during those cycles, `valid_out`=0 for the 3 following cycles, `data_out` holds its last value, and `ptr` is unchanged. The stream resumes at the lane after the last one served.
- Reset mid-stream: drop `reset_L` between edges while `valid_out`=1 -> `valid_out`, `data_out`, `lane_out` go to 0 without waiting for `clk`. After release, rotation restarts at lane 0.
- With `MUX_PARITY_EN`: lane 0 word 0x07 -> `parity_out`=1; lane 1 word 0x03 -> `parity_out`=0. Each value is aligned with its `data_out`.

Source files
------------

// File: rtl/mux_rr_4to1.sv
// mux_rr_4to1: four-lane round-robin merge of show-ahead FIFOs into one registered stream.
// Optional MUX_PARITY_EN adds a registered even-parity output aligned with data_out.
module mux_rr_4to1 #(
    parameter int BW = 8
) (
    input  logic          clk,
    input  logic          reset_L,
    input  logic [BW-1:0] data_in0,
    input  logic [BW-1:0] data_in1,
    input  logic [BW-1:0] data_in2,
    input  logic [BW-1:0] data_in3,
    input  logic [3:0]    empty,
    input  logic          pause,
    output logic [3:0]    pop,
    output logic [BW-1:0] data_out,
    output logic          valid_out,
`ifdef MUX_PARITY_EN
    output logic          parity_out,
`endif
    output logic [1:0]    lane_out
);
    typedef enum logic {INIT, ACTIVE} state_t;
    state_t        r_state;
    logic [1:0]    r_ptr;
    logic [BW-1:0] r_data;
    logic [1:0]    r_lane;
    logic          r_valid;
    logic [1:0]    w_p1, w_p2, w_p3, w_sel;
    logic          w_grant;
    logic [BW-1:0] w_lane [4];
    assign w_p1 = r_ptr + 2'd1;
    assign w_p2 = r_ptr + 2'd2;
    assign w_p3 = r_ptr + 2'd3;
    // First non-empty lane in rotation order starting at the pointer.
    assign w_sel = !empty[r_ptr] ? r_ptr : !empty[w_p1] ? w_p1 : !empty[w_p2] ? w_p2 : w_p3;
    assign w_grant = (r_state == ACTIVE) && !pause && reset_L && !(&empty);
    assign pop = w_grant ? 4'b0001 << w_sel : 4'b0000;
    assign w_lane[0] = data_in0;
    assign w_lane[1] = data_in1;
    assign w_lane[2] = data_in2;
    assign w_lane[3] = data_in3;
    assign data_out  = r_data;
    assign valid_out = r_valid;
    assign lane_out  = r_lane;
`ifdef MUX_PARITY_EN
    logic r_par;
    assign parity_out = r_par;
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L)
            r_par <= 1'b0;
        else if (w_grant)
            r_par <= ^w_lane[w_sel];
    end
`endif
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state <= INIT;
            r_ptr   <= 2'd0;
            r_data  <= '0;
            r_lane  <= 2'd0;
            r_valid <= 1'b0;
        end else begin
            r_state <= ACTIVE;
            r_valid <= w_grant;
            if (w_grant) begin
                r_data <= w_lane[w_sel];
                r_lane <= w_sel;
                r_ptr  <= w_sel + 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_mux_rr_4to1.sv
// tb_mux_rr_4to1: directed and randomized checks of mux_rr_4to1 against a lane-search model.
module tb_mux_rr_4to1;
    logic       clk = 1'b0;
    logic       reset_L;
    logic [7:0] din [4];
    logic [3:0] empty;
    logic       pause;
    logic [3:0] pop;
    logic [7:0] data_out;
    logic       valid_out;
    logic [1:0] lane_out;
`ifdef MUX_PARITY_EN
    logic       parity_out;
    bit         m_par;
`endif
    int checks = 0;
    int failures = 0;
    int m_ptr;
    bit m_active;
    bit m_valid;
    logic [7:0] m_data;
    int m_lane;

    always #5 clk = ~clk;

    mux_rr_4to1 #(.BW(8)) dut (
        .clk(clk), .reset_L(reset_L),
        .data_in0(din[0]), .data_in1(din[1]), .data_in2(din[2]), .data_in3(din[3]),
        .empty(empty), .pause(pause), .pop(pop),
        .data_out(data_out), .valid_out(valid_out),
`ifdef MUX_PARITY_EN
        .parity_out(parity_out),
`endif
        .lane_out(lane_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_active = 0; m_valid = 0; m_data = 8'h00; m_lane = 0;
`ifdef MUX_PARITY_EN
        m_par = 0;
`endif
    endtask

    task automatic check_regs();
        check("valid_out", 32'(valid_out), 32'(m_valid));
        check("data_out", 32'(data_out), 32'(m_data));
        check("lane_out", 32'(lane_out), 32'(m_lane));
`ifdef MUX_PARITY_EN
        check("parity_out", 32'(parity_out), 32'(m_par));
`endif
    endtask

    task automatic cycle(input logic [3:0] e, input bit p);
        int sel;
        int k;
        @(negedge clk);
        empty = e;
        pause = p;
        #1;
        sel = -1;
        if (m_active && !p)
            for (int i = 0; i < 4; i++) begin
                k = (m_ptr + i) % 4;
                if (sel < 0 && !e[k]) sel = k;
            end
        check("pop", 32'(pop), sel < 0 ? 32'd0 : 32'd1 << sel);
        @(posedge clk);
        m_active = 1;
        m_valid = (sel >= 0);
        if (sel >= 0) begin
            m_data = din[sel];
            m_lane = sel;
            m_ptr = (sel + 1) % 4;
`ifdef MUX_PARITY_EN
            m_par = ^din[sel];
`endif
        end
        #1 check_regs();
    endtask

    initial begin
        reset_L = 1'b0;
        empty = 4'b0000;
        pause = 1'b0;
        din[0] = 8'hA0; din[1] = 8'hB1; din[2] = 8'hC2; din[3] = 8'hD3;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        check("rst_pop", 32'(pop), 32'd0);
        check_regs();
        reset_L = 1'b1;
        for (int i = 0; i < 6; i++) cycle(4'b0000, 1'b0);
        for (int i = 0; i < 3; i++) cycle(4'b0000, 1'b1);
        for (int i = 0; i < 2; i++) cycle(4'b0000, 1'b0);
        for (int i = 0; i < 5; i++) cycle(4'b1010, 1'b0);
        cycle(4'b1111, 1'b0);
`ifdef MUX_PARITY_EN
        din[0] = 8'h07; din[1] = 8'h03;
        for (int i = 0; i < 4; i++) cycle(4'b1100, 1'b0);
`endif
        cycle(4'b0000, 1'b0);
        #2 reset_L = 1'b0;
        model_reset();
        #1;
        check("midrst_pop", 32'(pop), 32'd0);
        check_regs();
        @(posedge clk);
        #2 reset_L = 1'b1;
        for (int i = 0; i < 3; i++) cycle(4'b0000, 1'b0);
        for (int n = 0; n < 400; n++) begin
            for (int j = 0; j < 4; j++) din[j] = 8'($urandom);
            cycle(4'($urandom), ($urandom_range(0, 3) == 0));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
